// File: rtl/riscv_csr_pkg.sv
// riscv_csr_pkg: machine-mode CSR addresses, interrupt codes, mstatus bit positions
// and the trap sequencer state encoding.
package riscv_csr_pkg;
   localparam logic [11:0] CSR_MSTATUS = 12'h300;
   localparam logic [11:0] CSR_MTVEC   = 12'h305;
   localparam logic [11:0] CSR_MEPC    = 12'h341;
   localparam logic [11:0] CSR_MCAUSE  = 12'h342;
   localparam logic [11:0] CSR_MTVAL   = 12'h343;
   localparam logic [3:0]  IRQ_MSI     = 4'd3;
   localparam logic [3:0]  IRQ_MTI     = 4'd7;
   localparam logic [3:0]  IRQ_MEI     = 4'd11;
   localparam int          MSTATUS_MIE  = 3;
   localparam int          MSTATUS_MPIE = 7;
   typedef enum logic [2:0] {IDLE, T_EPC, T_CAUSE, T_TVAL, T_STAT, T_VEC, M_STAT, M_EPC} trap_state_t;
endpackage

// File: rtl/irq_prio_enc.sv
// irq_prio_enc: picks the highest-priority pending machine interrupt (MEI > MSI > MTI).
module irq_prio_enc
   import riscv_csr_pkg::*;
(
   input  logic [2:0] irq_pend_i,
   output logic       any_o,
   output logic [3:0] code_o
);
   assign any_o  = |irq_pend_i;
   assign code_o = irq_pend_i[2] ? IRQ_MEI : irq_pend_i[0] ? IRQ_MSI : irq_pend_i[1] ? IRQ_MTI : 4'd0;
endmodule

// File: rtl/trap_sequencer.sv
// trap_sequencer: arbitrates the single CSR port between Zicsr accesses and the
// multi-cycle trap entry / MRET sequences, and issues the resulting PC redirect.
module trap_sequencer
   import riscv_csr_pkg::*;
#(
   parameter int XLEN        = 32,
   parameter bit VECTORED_EN = 1'b1
) (
   input  logic            ctrl_clk,
   input  logic            ctrl_reset_n,
   input  logic            exc_valid,
   input  logic [3:0]      exc_cause,
   input  logic [XLEN-1:0] exc_pc,
   input  logic [XLEN-1:0] exc_tval,
   input  logic            mret_valid,
   input  logic [2:0]      irq_pend,
   input  logic            ins_req,
   input  logic [11:0]     ins_addr,
   input  logic [XLEN-1:0] ins_wdata,
   input  logic            ins_wen,
   output logic            ins_gnt,
   output logic [XLEN-1:0] ins_rdata,
   output logic [11:0]     csr_addr,
   output logic [XLEN-1:0] csr_wdata,
   output logic            csr_wen,
   input  logic [XLEN-1:0] csr_rdata,
   input  logic            ctrl_mie,
   output logic            busy,
   output logic            redir_valid,
   output logic [XLEN-1:0] redir_pc
);
   trap_state_t     state_q, state_d;
   logic [XLEN-1:0] epc_q, epc_d, mcause_q, mcause_d, tval_q, tval_d;
   logic            irq_any, irq_evt, any_evt, vec_mode;
   logic [3:0]      irq_code;
   logic [XLEN-1:0] base;

   irq_prio_enc u_enc (
      .irq_pend_i (irq_pend),
      .any_o      (irq_any),
      .code_o     (irq_code)
   );

   assign irq_evt  = ctrl_mie && irq_any;
   assign any_evt  = exc_valid || mret_valid || irq_evt;
   assign base     = {csr_rdata[XLEN-1:2], 2'b00};
   assign vec_mode = VECTORED_EN && (csr_rdata[1:0] == 2'b01) && mcause_q[XLEN-1];

   always_comb begin
      state_d     = state_q;
      epc_d       = epc_q;
      mcause_d    = mcause_q;
      tval_d      = tval_q;
      ins_gnt     = 1'b0;
      ins_rdata   = '0;
      csr_addr    = '0;
      csr_wdata   = '0;
      csr_wen     = 1'b0;
      busy        = state_q != IDLE;
      redir_valid = 1'b0;
      redir_pc    = '0;
      case (state_q)
         IDLE: begin
            busy = any_evt;
            if (exc_valid) begin
               epc_d    = exc_pc;
               mcause_d = XLEN'(exc_cause);
               tval_d   = exc_tval;
               state_d  = T_EPC;
            end else if (mret_valid) begin
               state_d = M_STAT;
            end else if (irq_evt) begin
               epc_d    = exc_pc;
               mcause_d = {1'b1, (XLEN-1)'(irq_code)};
               tval_d   = '0;
               state_d  = T_EPC;
            end else if (ins_req) begin
               ins_gnt   = 1'b1;
               csr_addr  = ins_addr;
               csr_wen   = ins_wen;
               csr_wdata = ins_wdata;
               ins_rdata = csr_rdata;
            end
         end
         T_EPC: begin
            csr_wen   = 1'b1;
            csr_addr  = CSR_MEPC;
            csr_wdata = epc_q & ~XLEN'(3);
            state_d   = T_CAUSE;
         end
         T_CAUSE: begin
            csr_wen   = 1'b1;
            csr_addr  = CSR_MCAUSE;
            csr_wdata = mcause_q;
            state_d   = T_TVAL;
         end
         T_TVAL: begin
            csr_wen   = 1'b1;
            csr_addr  = CSR_MTVAL;
            csr_wdata = tval_q;
            state_d   = T_STAT;
         end
         // read-modify-write of mstatus within one cycle: MPIE <= MIE, MIE <= 0
         T_STAT: begin
            csr_wen                 = 1'b1;
            csr_addr                = CSR_MSTATUS;
            csr_wdata               = csr_rdata;
            csr_wdata[MSTATUS_MPIE] = csr_rdata[MSTATUS_MIE];
            csr_wdata[MSTATUS_MIE]  = 1'b0;
            state_d                 = T_VEC;
         end
         T_VEC: begin
            csr_addr    = CSR_MTVEC;
            redir_valid = 1'b1;
            redir_pc    = vec_mode ? base + (XLEN'(mcause_q[3:0]) << 2) : base;
            state_d     = IDLE;
         end
         M_STAT: begin
            csr_wen                 = 1'b1;
            csr_addr                = CSR_MSTATUS;
            csr_wdata               = csr_rdata;
            csr_wdata[MSTATUS_MIE]  = csr_rdata[MSTATUS_MPIE];
            csr_wdata[MSTATUS_MPIE] = 1'b1;
            state_d                 = M_EPC;
         end
         M_EPC: begin
            csr_addr    = CSR_MEPC;
            redir_valid = 1'b1;
            redir_pc    = base;
            state_d     = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge ctrl_clk or negedge ctrl_reset_n) begin
      if (!ctrl_reset_n) begin
         state_q  <= IDLE;
         epc_q    <= '0;
         mcause_q <= '0;
         tval_q   <= '0;
      end else begin
         state_q  <= state_d;
         epc_q    <= epc_d;
         mcause_q <= mcause_d;
         tval_q   <= tval_d;
      end
   end
endmodule

// File: tb/tb_trap_sequencer.sv
// tb_trap_sequencer: directed bench with a behavioural CSR file; idle arbitration via
// a vector table, trap/MRET/reset sequences hand-written.
module tb_trap_sequencer;
   logic        clk = 1'b0, rst_n = 1'b0;
   logic        exc_valid = 0, mret_valid = 0, ins_req = 0, ins_wen = 0, ctrl_mie = 0;
   logic [3:0]  exc_cause = 0;
   logic [31:0] exc_pc = 0, exc_tval = 0, ins_wdata = 0, csr_rdata;
   logic [2:0]  irq_pend = 0;
   logic [11:0] ins_addr = 0, csr_addr;
   logic        ins_gnt, csr_wen, busy, redir_valid;
   logic [31:0] ins_rdata, csr_wdata, redir_pc;
   logic        pl_en = 0;
   logic [11:0] pl_addr = 0;
   logic [31:0] pl_data = 0;
   logic [31:0] csr_mem [0:4095];
   int          total = 0, bad = 0;

   always #5 clk = ~clk;

   trap_sequencer dut (
      .ctrl_clk(clk), .ctrl_reset_n(rst_n),
      .exc_valid(exc_valid), .exc_cause(exc_cause), .exc_pc(exc_pc), .exc_tval(exc_tval),
      .mret_valid(mret_valid), .irq_pend(irq_pend),
      .ins_req(ins_req), .ins_addr(ins_addr), .ins_wdata(ins_wdata), .ins_wen(ins_wen),
      .ins_gnt(ins_gnt), .ins_rdata(ins_rdata),
      .csr_addr(csr_addr), .csr_wdata(csr_wdata), .csr_wen(csr_wen), .csr_rdata(csr_rdata),
      .ctrl_mie(ctrl_mie), .busy(busy), .redir_valid(redir_valid), .redir_pc(redir_pc)
   );

   // behavioural csr_file: combinational read, write on clock edge, bench preload port
   assign csr_rdata = csr_mem[csr_addr];
   always @(posedge clk) begin
      if (pl_en) csr_mem[pl_addr] <= pl_data;
      else if (csr_wen) csr_mem[csr_addr] <= csr_wdata;
   end

   typedef struct {
      logic        exc, mret;
      logic [2:0]  irq;
      logic        mie, req, wen;
      logic [11:0] addr;
      logic [31:0] wdata;
      logic        e_gnt, e_busy, e_wen;
      logic [11:0] e_addr;
      logic [31:0] e_wdata;
   } vec_t;
   vec_t vt [8];

   task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", nm, act, exp);
      end
   endtask

   task automatic preload(input logic [11:0] a, input logic [31:0] d);
      @(negedge clk);
      pl_en = 1; pl_addr = a; pl_data = d;
      @(negedge clk);
      pl_en = 0;
   endtask

   task automatic clear_evt();
      exc_valid = 0; mret_valid = 0; irq_pend = 0;
   endtask

   // walks one cycle past the redirect; event must already have been sampled at the next edge
   task automatic run_seq(input string nm, input int lat, input logic [31:0] pc);
      for (int k = 1; k <= lat + 1; k++) begin
         @(negedge clk);
         clear_evt();
         #1;
         check($sformatf("%s_c%0d_busy_redir_gnt", nm, k), {busy, redir_valid, ins_gnt},
               {k <= lat, k == lat, (k > lat) && ins_req});
         if (k == lat) check($sformatf("%s_redir_pc", nm), redir_pc, pc);
      end
   endtask

   initial begin
      logic seen;
      vt[0] = '{0, 0, 3'b000, 0, 1, 1, 12'h340, 32'hDEADBEEF, 1, 0, 1, 12'h340, 32'hDEADBEEF};
      vt[1] = '{0, 0, 3'b000, 0, 1, 0, 12'h305, 32'h00000055, 1, 0, 0, 12'h305, 32'h00000055};
      vt[2] = '{1, 0, 3'b000, 0, 1, 1, 12'h340, 32'h11111111, 0, 1, 0, 12'h000, 32'h0};
      vt[3] = '{0, 1, 3'b000, 0, 1, 1, 12'h340, 32'h22222222, 0, 1, 0, 12'h000, 32'h0};
      vt[4] = '{0, 0, 3'b010, 1, 1, 1, 12'h340, 32'h33333333, 0, 1, 0, 12'h000, 32'h0};
      vt[5] = '{0, 0, 3'b111, 0, 1, 1, 12'h340, 32'h44444444, 1, 0, 1, 12'h340, 32'h44444444};
      vt[6] = '{0, 0, 3'b000, 1, 0, 0, 12'h340, 32'h55555555, 0, 0, 0, 12'h000, 32'h0};
      vt[7] = '{1, 1, 3'b001, 1, 0, 0, 12'h000, 32'h0, 0, 1, 0, 12'h000, 32'h0};

      #12;
      check("reset_outputs", {busy, redir_valid, csr_wen, ins_gnt, csr_addr, csr_wdata, redir_pc}, 64'd0);
      @(negedge clk);
      rst_n = 1;

      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         exc_valid = vt[i].exc; mret_valid = vt[i].mret; irq_pend = vt[i].irq; ctrl_mie = vt[i].mie;
         ins_req = vt[i].req; ins_wen = vt[i].wen; ins_addr = vt[i].addr; ins_wdata = vt[i].wdata;
         #1;
         check($sformatf("vec%0d", i), {ins_gnt, busy, csr_wen, redir_valid, csr_addr, csr_wdata},
               {vt[i].e_gnt, vt[i].e_busy, vt[i].e_wen, 1'b0, vt[i].e_addr, vt[i].e_wdata});
         #1;
         clear_evt(); ctrl_mie = 0; ins_req = 0; ins_wen = 0;
      end

      // real idle write then read back
      @(negedge clk);
      ins_req = 1; ins_wen = 1; ins_addr = 12'h340; ins_wdata = 32'hDEADBEEF;
      @(negedge clk);
      ins_wen = 0;
      #1;
      check("idle_read_back", {ins_gnt, ins_rdata}, {1'b1, 32'hDEADBEEF});
      ins_req = 0;

      // exception colliding with an instruction write
      preload(12'h305, 32'h8000);
      preload(12'h300, 32'h8);
      @(negedge clk);
      exc_valid = 1; exc_cause = 4'd2; exc_pc = 32'h100; exc_tval = 32'h13;
      ins_req = 1; ins_wen = 1; ins_addr = 12'h340; ins_wdata = 32'h1234;
      #1;
      check("exc_collide_gnt_busy", {ins_gnt, busy}, 2'b01);
      run_seq("exc", 5, 32'h8000);
      @(negedge clk);
      ins_req = 0; ins_wen = 0;
      check("exc_mepc", csr_mem[12'h341], 32'h100);
      check("exc_mcause", csr_mem[12'h342], 32'h2);
      check("exc_mtval", csr_mem[12'h343], 32'h13);
      check("exc_mstatus", csr_mem[12'h300], 32'h80);
      check("collide_late_write", csr_mem[12'h340], 32'h1234);

      // vectored interrupt, all three pending
      preload(12'h305, 32'h8001);
      preload(12'h300, 32'h8);
      @(negedge clk);
      irq_pend = 3'b111; ctrl_mie = 1; exc_pc = 32'h206; exc_tval = 32'hFFFF;
      #1;
      check("irq_busy", busy, 1'b1);
      run_seq("irq", 5, 32'h802C);
      ctrl_mie = 0;
      check("irq_mcause", csr_mem[12'h342], 32'h8000000B);
      check("irq_mtval", csr_mem[12'h343], 32'h0);
      check("irq_mepc_aligned", csr_mem[12'h341], 32'h204);

      // exception with mtvec in vectored mode still goes to base
      @(negedge clk);
      exc_valid = 1; exc_cause = 4'd5; exc_pc = 32'h300; exc_tval = 32'h0;
      run_seq("exc_vecmode", 5, 32'h8000);

      // MRET
      preload(12'h300, 32'h80);
      preload(12'h341, 32'h204);
      @(negedge clk);
      mret_valid = 1;
      #1;
      check("mret_busy", busy, 1'b1);
      run_seq("mret", 2, 32'h204);
      check("mret_mstatus", csr_mem[12'h300], 32'h88);

      // async reset in T_CAUSE
      preload(12'h342, 32'h77);
      @(negedge clk);
      exc_valid = 1; exc_cause = 4'd1; exc_pc = 32'h400; exc_tval = 32'h9;
      @(negedge clk);
      clear_evt();
      @(negedge clk);
      #1;
      check("in_t_cause_wen_addr", {csr_wen, csr_addr}, {1'b1, 12'h342});
      rst_n = 0;
      #1;
      check("abort_outputs", {busy, redir_valid, csr_wen, ins_gnt, csr_addr, csr_wdata, redir_pc}, 64'd0);
      @(negedge clk);
      rst_n = 1;
      seen = 0;
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         #1;
         seen = seen | busy | redir_valid;
      end
      check("abort_no_redirect", seen, 1'b0);
      check("abort_mepc_stands", csr_mem[12'h341], 32'h400);
      check("abort_mcause_untouched", csr_mem[12'h342], 32'h77);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
